ram_lsu_q: RTL and testbench

- Parametrised, queued load/store engine between an accelerator datapath in exu and a single-port synchronous RAM.
- Adds the following:
  - valid/ready request and response handshakes;
  - a request FIFO;
  - byte/half/word(/double) access sizes with byte enables and sign extension;
  - a misalignment error response;
  - a configurable RAM read latency.
- Executes one RAM access at a time, in order.

---
 rtl/ram_lsu_q.sv | 202 ++++++++++++++++++++
 tb/tb_ram_lsu_q.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_lsu_q.sv
// Queued load/store engine: buffers requests in a FIFO and runs them one at a
// time, in order, against a single-port synchronous RAM with fixed read latency.
module ram_lsu_q #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_store,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  input  logic [AW-1:0]            req_addr,
  input  logic [DW-1:0]            req_wdata,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_store,
  output logic                     resp_err,
  output logic [DW-1:0]            resp_rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [DW/8-1:0]          ram_be,
  output logic [AW-1:0]            ram_addr,
  output logic [DW-1:0]            ram_wdata,
  input  logic [DW-1:0]            ram_rdata,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int NB   = DW / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(RD_LAT + 1);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic          store;
    logic [1:0]    size;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  req_t            fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     count_q;
  state_t          state_q, state_d;
  req_t            op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            resp_store_q, resp_store_d;
  logic            resp_err_q, resp_err_d;
  logic [DW-1:0]   resp_rdata_q, resp_rdata_d;

  logic            push, pop;
  req_t            head, new_req;
  logic [OFFW-1:0] off;
  logic [OFFW+2:0] shamt;
  logic [NB-1:0]   be_base;
  logic [DW-1:0]   lane, load_ext;

  // Size-alignment check; a double access is only legal on a 64-bit datapath.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return |a[1:0];
      default: return (DW == 32) || (|a);
    endcase
  endfunction

  assign req_ready  = (count_q < FULL);
  assign push       = req_valid && req_ready;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign head       = fifo_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

  always_comb begin
    new_req       = '0;
    new_req.store = req_store;
    new_req.size  = req_size;
    new_req.sgn   = req_signed;
    new_req.addr  = req_addr;
    new_req.wdata = req_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_req;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + (PW+1)'(1);
      else if (pop && !push) count_q <= count_q - (PW+1)'(1);
    end
  end

  // Lane placement: byte enables, store data and load extraction all key off
  // the low address bits of the operation currently being executed.
  always_comb begin
    off   = op_q.addr[OFFW-1:0];
    shamt = {off, 3'b000};
    case (op_q.size)
      2'd0:    be_base = NB'(1);
      2'd1:    be_base = NB'(3);
      2'd2:    be_base = NB'(15);
      default: be_base = '1;
    endcase
    lane = ram_rdata >> shamt;
    case (op_q.size)
      2'd0:    load_ext = op_q.sgn ? DW'($signed(lane[7:0]))  : DW'(lane[7:0]);
      2'd1:    load_ext = op_q.sgn ? DW'($signed(lane[15:0])) : DW'(lane[15:0]);
      2'd2:    load_ext = op_q.sgn ? DW'($signed(lane[31:0])) : DW'(lane[31:0]);
      default: load_ext = lane;
    endcase
  end

  assign ram_en    = (state_q == ACCESS);
  assign ram_we    = ram_en && op_q.store;
  assign ram_be    = ram_en ? (be_base << off) : '0;
  assign ram_addr  = ram_en ? {op_q.addr[AW-1:OFFW], {OFFW{1'b0}}} : '0;
  assign ram_wdata = ram_en ? (op_q.wdata << shamt) : '0;

  assign resp_valid = (state_q == RESP);
  assign resp_store = resp_store_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    resp_store_d = resp_store_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          op_d         = head;
          resp_store_d = head.store;
          resp_rdata_d = '0;
          if (misaligned(head.size, head.addr[2:0])) begin
            resp_err_d = 1'b1;
            state_d    = RESP;
          end else begin
            resp_err_d = 1'b0;
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (op_q.store) begin
          state_d = RESP;
        end else begin
          cnt_d   = CW'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(RD_LAT)) begin
          resp_rdata_d = load_ext;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (resp_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      op_q         <= '0;
      cnt_q        <= '0;
      resp_store_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      resp_store_q <= resp_store_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ram_lsu_q.sv
// Bench for ram_lsu_q: directed cycle checks plus a randomized run scored
// against a byte-addressed memory model of the load/store rules.
module tb_ram_lsu_q;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_store, resp_err;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        ram_en, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        busy;
  logic [2:0]  fifo_count;

  logic        w_req_valid = 1'b0, w_req_store = 1'b0, w_req_signed = 1'b0;
  logic [1:0]  w_req_size = '0;
  logic [31:0] w_req_addr = '0;
  logic [63:0] w_req_wdata = '0;
  logic        w_req_ready, w_resp_valid, w_resp_store, w_resp_err;
  logic [63:0] w_resp_rdata, w_ram_wdata;
  logic        w_ram_en, w_ram_we, w_busy;
  logic [7:0]  w_ram_be;
  logic [31:0] w_ram_addr;
  logic [2:0]  w_fifo_count;
  logic [63:0] w_ram_rdata = 64'h8765_4321_0000_0000;

  always #5 clk = ~clk;

  ram_lsu_q #(.AW(32), .DW(32), .DEPTH(4), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_store(resp_store),
    .resp_err(resp_err), .resp_rdata(resp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .fifo_count(fifo_count)
  );

  ram_lsu_q #(.AW(32), .DW(64), .DEPTH(4), .RD_LAT(1)) u_dut64 (
    .clk(clk), .rst_l(rst_l),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_store(w_req_store),
    .req_size(w_req_size), .req_signed(w_req_signed), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata),
    .resp_valid(w_resp_valid), .resp_ready(1'b1), .resp_store(w_resp_store),
    .resp_err(w_resp_err), .resp_rdata(w_resp_rdata),
    .ram_en(w_ram_en), .ram_we(w_ram_we), .ram_be(w_ram_be), .ram_addr(w_ram_addr),
    .ram_wdata(w_ram_wdata), .ram_rdata(w_ram_rdata),
    .busy(w_busy), .fifo_count(w_fifo_count)
  );

  // Environment RAM: 256 bytes, read data valid RD_LAT cycles after the access.
  logic [31:0] ramMem [64] = '{default: 32'h0};
  logic [31:0] rdPipe [RD_LAT] = '{default: 32'h0};
  assign ram_rdata = rdPipe[RD_LAT-1];

  always @(posedge clk) begin
    if (ram_en && ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ramMem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    rdPipe[0] <= ramMem[ram_addr[7:2]];
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  typedef struct {
    logic        store;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t       expQ [$];
  logic [7:0] refMem [256] = '{default: 8'h0};
  int         checkCount = 0, passCount = 0, failCount = 0, acceptCount = 0;
  bit         pushed;
  bit         sawResp;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: in-order byte memory, responses predicted at acceptance time.
  task automatic modelPush(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
    int     n, ai;
    longint v;
    exp_t   e;
    n = 1 << sz;
    ai = int'(a[7:0]);
    e.store = st;
    e.rdata = 32'h0;
    e.err = (sz == 2'd3) || ((a % n) != 0);
    if (!e.err && st) begin
      for (int i = 0; i < n; i++) refMem[ai+i] = wd[8*i +: 8];
    end else if (!e.err) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(refMem[ai+i]) << (8*i));
      if (sg && refMem[ai+n-1][7]) v = v - (longint'(1) << (8*n));
      e.rdata = v[31:0];
    end
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic v, input logic st, input logic [1:0] sz,
                               input logic sg, input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_store  = st;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  // One clock: score handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    pushed = 1'b0;
    if (req_valid && req_ready) begin
      modelPush(req_store, req_size, req_signed, req_addr, req_wdata);
      pushed = 1'b1;
      acceptCount++;
    end
    if (resp_valid && resp_ready) begin
      checkOutput("resp_expected", 64'(expQ.size() != 0), 64'h1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("resp_store", 64'(resp_store), 64'(e.store));
        checkOutput("resp_err", 64'(resp_err), 64'(e.err));
        checkOutput("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int c;
    c = 0;
    while ((busy || expQ.size() != 0) && c < 200) begin
      tick();
      c++;
    end
    checkOutput("idle_reached", 64'(c < 200), 64'h1);
  endtask

  task automatic loadByte13(input logic sg, input logic [31:0] expData);
    applyStimulus(1, 0, 2'd0, sg, 32'h13, 32'h0);
    tick();
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    tick();
    checkOutput("ld_ram_en", 64'(ram_en), 64'h1);
    checkOutput("ld_ram_we", 64'(ram_we), 64'h0);
    checkOutput("ld_ram_be", 64'(ram_be), 64'h8);
    checkOutput("ld_ram_addr", 64'(ram_addr), 64'h10);
    tick();
    checkOutput("ld_wait1_resp", 64'(resp_valid), 64'h0);
    tick();
    checkOutput("ld_wait2_resp", 64'(resp_valid), 64'h0);
    tick();
    checkOutput("ld_resp_valid", 64'(resp_valid), 64'h1);
    checkOutput("ld_resp_rdata", 64'(resp_rdata), 64'(expData));
    tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int          k, c;

    $display("[TB] reset state");
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'h1);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'h0);
    checkOutput("rst_ram_en", 64'(ram_en), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_fifo_count", 64'(fifo_count), 64'h0);
    checkOutput("rst_resp_rdata", 64'(resp_rdata), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    tick();

    $display("[TB] store word");
    applyStimulus(1, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);
    tick();
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    checkOutput("st_fifo_count_c1", 64'(fifo_count), 64'h1);
    tick();
    checkOutput("st_ram_en", 64'(ram_en), 64'h1);
    checkOutput("st_ram_we", 64'(ram_we), 64'h1);
    checkOutput("st_ram_be", 64'(ram_be), 64'hF);
    checkOutput("st_ram_addr", 64'(ram_addr), 64'h10);
    checkOutput("st_ram_wdata", 64'(ram_wdata), 64'hDEAD_BEEF);
    tick();
    checkOutput("st_resp_valid", 64'(resp_valid), 64'h1);
    checkOutput("st_resp_store", 64'(resp_store), 64'h1);
    checkOutput("st_resp_err", 64'(resp_err), 64'h0);
    tick();
    checkOutput("st_busy_after", 64'(busy), 64'h0);

    $display("[TB] load byte signed/unsigned");
    applyStimulus(1, 1, 2'd2, 0, 32'h10, 32'h80FF_0000);
    tick();
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    waitIdle();
    loadByte13(1'b1, 32'hFFFF_FF80);
    loadByte13(1'b0, 32'h0000_0080);

    $display("[TB] misaligned half");
    applyStimulus(1, 0, 2'd1, 0, 32'h11, 32'h0);
    tick();
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    checkOutput("mis_ram_en_c1", 64'(ram_en), 64'h0);
    tick();
    checkOutput("mis_ram_en_c2", 64'(ram_en), 64'h0);
    checkOutput("mis_resp_valid", 64'(resp_valid), 64'h1);
    checkOutput("mis_resp_err", 64'(resp_err), 64'h1);
    checkOutput("mis_resp_rdata", 64'(resp_rdata), 64'h0);
    tick();

    $display("[TB] double on 32-bit datapath");
    applyStimulus(1, 1, 2'd3, 0, 32'h8, 32'h1234_5678);
    tick();
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    tick();
    checkOutput("dbl32_ram_en", 64'(ram_en), 64'h0);
    checkOutput("dbl32_resp_err", 64'(resp_err), 64'h1);
    waitIdle();

    $display("[TB] fifo full under backpressure");
    resp_ready = 1'b0;
    acceptCount = 0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (k < 6)
        applyStimulus(1, (k % 2) == 0, 2'd2, 1, 32'h20 + 32'(4 * (k / 2)), 32'hA000_0000 + 32'(k));
      else
        applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
      tick();
      if (pushed) k++;
    end
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    checkOutput("full_accepted", 64'(acceptCount), 64'd5);
    checkOutput("full_req_ready", 64'(req_ready), 64'h0);
    checkOutput("full_fifo_count", 64'(fifo_count), 64'd4);
    checkOutput("full_resp_held", 64'(resp_valid), 64'h1);
    resp_ready = 1'b1;
    waitIdle();
    checkOutput("full_drained_count", 64'(fifo_count), 64'h0);

    $display("[TB] reset during load wait");
    applyStimulus(1, 0, 2'd2, 0, 32'h20, 32'h0);
    tick();
    applyStimulus(1, 0, 2'd2, 0, 32'h24, 32'h0);
    tick();
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    tick();
    checkOutput("rl_fifo_before", 64'(fifo_count), 64'h1);
    rst_l = 1'b0;
    #1;
    checkOutput("rl_ram_en", 64'(ram_en), 64'h0);
    checkOutput("rl_resp_valid", 64'(resp_valid), 64'h0);
    checkOutput("rl_fifo_count", 64'(fifo_count), 64'h0);
    checkOutput("rl_busy", 64'(busy), 64'h0);
    expQ.delete();
    tick();
    rst_l = 1'b1;
    sawResp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid) sawResp = 1'b1;
    end
    checkOutput("rl_no_resp_after", 64'(sawResp), 64'h0);

    $display("[TB] 64-bit datapath");
    w_req_valid = 1; w_req_store = 1; w_req_size = 2'd3; w_req_addr = 32'h8;
    w_req_wdata = 64'h1122_3344_5566_7788;
    tick();
    w_req_valid = 0;
    tick();
    checkOutput("w_st_ram_en", 64'(w_ram_en), 64'h1);
    checkOutput("w_st_ram_we", 64'(w_ram_we), 64'h1);
    checkOutput("w_st_ram_be", 64'(w_ram_be), 64'hFF);
    checkOutput("w_st_ram_addr", 64'(w_ram_addr), 64'h8);
    checkOutput("w_st_ram_wdata", w_ram_wdata, 64'h1122_3344_5566_7788);
    tick();
    checkOutput("w_st_resp_valid", 64'(w_resp_valid), 64'h1);
    checkOutput("w_st_resp_err", 64'(w_resp_err), 64'h0);
    tick();
    w_req_valid = 1; w_req_store = 0; w_req_size = 2'd2; w_req_signed = 1; w_req_addr = 32'hC;
    tick();
    w_req_valid = 0;
    tick();
    checkOutput("w_ld_ram_be", 64'(w_ram_be), 64'hF0);
    checkOutput("w_ld_ram_addr", 64'(w_ram_addr), 64'h8);
    tick();
    checkOutput("w_ld_wait_resp", 64'(w_resp_valid), 64'h0);
    tick();
    checkOutput("w_ld_resp_valid", 64'(w_resp_valid), 64'h1);
    checkOutput("w_ld_resp_rdata", w_resp_rdata, 64'hFFFF_FFFF_8765_4321);
    tick();
    w_req_valid = 1; w_req_store = 1; w_req_size = 2'd3; w_req_addr = 32'h4;
    tick();
    w_req_valid = 0;
    tick();
    checkOutput("w_mis_ram_en", 64'(w_ram_en), 64'h0);
    checkOutput("w_mis_resp_err", 64'(w_resp_err), 64'h1);
    tick();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz,
                    1'($urandom_range(0, 1)), a, $urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    applyStimulus(0, 0, 2'd0, 0, 32'h0, 32'h0);
    resp_ready = 1'b1;
    waitIdle();
    c = expQ.size();
    checkOutput("rand_all_responses", 64'(c), 64'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
